// File: rtl/ex_mul_pkg.sv
// Shared definitions for the EX-stage pipelined multiplier.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package ex_mul_pkg;

    // Operand limb width used for partial-product generation
    localparam int LIMB_W = 16;

    // Non-held clock edges from operand sampling to a visible result
    localparam int MUL_LATENCY = 4;

    // opMode encodings
    typedef enum logic [1:0] {
        MUL_UU  = 2'b00,
        MUL_SS  = 2'b01,
        MUL_SU  = 2'b10,
        MUL_MAC = 2'b11
    } mul_mode_e;

    // Rs is two's complement in every mode except UU
    function automatic logic rs_is_signed(input mul_mode_e mode);
        return mode != MUL_UU;
    endfunction

    // Rt is two's complement in SS and in the accumulate mode (which is SS underneath)
    function automatic logic rt_is_signed(input mul_mode_e mode);
        return (mode == MUL_SS) || (mode == MUL_MAC);
    endfunction

endpackage

// File: rtl/ex_mul_csa_add.sv
// Two-input W-bit carry-select adder, split into halves with one register level.
// Latency: 1 cycle (halves registered, upper-half select after the register).
// Backpressure: en = 0 freezes the internal registers.
module ex_mul_csa_add #(
    parameter int W = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    localparam int LW = W / 2;
    localparam int HW = W - LW;

    logic [LW:0]   lo_c;
    logic [HW-1:0] hi0_c;
    logic [HW-1:0] hi1_c;

    logic [LW-1:0] lo_q;
    logic          lo_cy_q;
    logic [HW-1:0] hi0_q;
    logic [HW-1:0] hi1_q;

    // Lower half with carry out; upper half precomputed for both carry-in values
    assign lo_c  = {1'b0, a[LW-1:0]} + {1'b0, b[LW-1:0]};
    assign hi0_c = a[W-1:LW] + b[W-1:LW];
    assign hi1_c = a[W-1:LW] + b[W-1:LW] + HW'(1);

    // Register both halves so neither carry chain spans the full width in one cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lo_q    <= '0;
            lo_cy_q <= 1'b0;
            hi0_q   <= '0;
            hi1_q   <= '0;
        end else if (en) begin
            lo_q    <= lo_c[LW-1:0];
            lo_cy_q <= lo_c[LW];
            hi0_q   <= hi0_c;
            hi1_q   <= hi1_c;
        end
    end

    assign sum = {(lo_cy_q ? hi1_q : hi0_q), lo_q};

endmodule

// File: rtl/ex_mul_pipe.sv
// Pipelined WIDTHxWIDTH -> 2*WIDTH multiplier (UU/SS/SU, optional MAC via EX_MUL_PIPE_MAC_EN).
// Latency: 4 non-held edges from operand sampling to outValid/valRn; one op per clock.
// Backpressure: hold = 1 freezes every register (valids and outputs); inputs ignored that cycle.
module ex_mul_pipe
    import ex_mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAGW  = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 hold,
    input  logic                 inValid,
    input  logic [1:0]           opMode,
    input  logic [WIDTH-1:0]     valRs,
    input  logic [WIDTH-1:0]     valRt,
`ifdef EX_MUL_PIPE_MAC_EN
    input  logic [2*WIDTH-1:0]   valAcc,
`endif
    input  logic [TAGW-1:0]      inTag,
    output logic                 outValid,
    output logic [2*WIDTH-1:0]   valRn,
    output logic [TAGW-1:0]      outTag,
    output logic                 busy
);

    localparam int N   = WIDTH / LIMB_W;
    localparam int NPP = N * N;
    localparam int PW  = 2 * WIDTH;
    localparam int PPW = 2 * LIMB_W;
`ifdef EX_MUL_PIPE_MAC_EN
    localparam int NADD = NPP + 2;
`else
    localparam int NADD = NPP + 1;
`endif

    // ---------------- S0: operand capture ----------------
    logic             s0_vld;
    mul_mode_e        s0_mode;
    logic [WIDTH-1:0] s0_rs;
    logic [WIDTH-1:0] s0_rt;
    logic [TAGW-1:0]  s0_tag;
`ifdef EX_MUL_PIPE_MAC_EN
    logic [PW-1:0]    s0_acc;
`endif

    // Capture operands every non-held cycle; the valid bit marks whether they matter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s0_vld  <= 1'b0;
            s0_mode <= MUL_UU;
            s0_rs   <= '0;
            s0_rt   <= '0;
            s0_tag  <= '0;
`ifdef EX_MUL_PIPE_MAC_EN
            s0_acc  <= '0;
`endif
        end else if (!hold) begin
            s0_vld  <= inValid;
            s0_mode <= mul_mode_e'(opMode);
            s0_rs   <= valRs;
            s0_rt   <= valRt;
            s0_tag  <= inTag;
`ifdef EX_MUL_PIPE_MAC_EN
            s0_acc  <= valAcc;
`endif
        end
    end

    // ---------------- S1: partial products and sign correction ----------------
    logic [PPW-1:0]   pp_c [NPP];
    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] corr_c;

    // Unsigned 16x16 products of every limb pair; signedness is handled by corr_c
    for (genvar gi = 0; gi < N; gi++) begin : g_pp_row
        for (genvar gj = 0; gj < N; gj++) begin : g_pp_col
            assign pp_c[gi*N+gj] = PPW'(s0_rs[gi*LIMB_W +: LIMB_W]) *
                                   PPW'(s0_rt[gj*LIMB_W +: LIMB_W]);
        end
    end

    // A negative signed operand is worth (value - 2^WIDTH), so subtract the other operand
    // from the upper half; the 2^(2*WIDTH) cross term vanishes modulo the result width.
    always_comb begin
        rs_neg = rs_is_signed(s0_mode) && s0_rs[WIDTH-1];
        rt_neg = rt_is_signed(s0_mode) && s0_rt[WIDTH-1];
        corr_c = '0;
        if (rs_neg) corr_c = corr_c - s0_rt;
        if (rt_neg) corr_c = corr_c - s0_rs;
    end

    logic             s1_vld;
    logic [TAGW-1:0]  s1_tag;
    logic [PPW-1:0]   s1_pp [NPP];
    logic [WIDTH-1:0] s1_corr;
`ifdef EX_MUL_PIPE_MAC_EN
    logic [PW-1:0]    s1_acc;
`endif

    // Register partial products; the addend is zeroed here unless the op accumulates
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_vld  <= 1'b0;
            s1_tag  <= '0;
            s1_corr <= '0;
            for (int k = 0; k < NPP; k++) s1_pp[k] <= '0;
`ifdef EX_MUL_PIPE_MAC_EN
            s1_acc  <= '0;
`endif
        end else if (!hold) begin
            s1_vld  <= s0_vld;
            s1_tag  <= s0_tag;
            s1_corr <= corr_c;
            for (int k = 0; k < NPP; k++) s1_pp[k] <= pp_c[k];
`ifdef EX_MUL_PIPE_MAC_EN
            s1_acc  <= (s0_mode == MUL_MAC) ? s0_acc : '0;
`endif
        end
    end

    // ---------------- S2: column alignment and carry-save reduction ----------------
    logic [PW-1:0] add_v [NADD];
    logic [PW-1:0] red_a;
    logic [PW-1:0] red_b;
    logic [PW-1:0] red_t;

    // Place each partial product at the column of its limb pair
    for (genvar gi = 0; gi < N; gi++) begin : g_al_row
        for (genvar gj = 0; gj < N; gj++) begin : g_al_col
            assign add_v[gi*N+gj] = PW'(s1_pp[gi*N+gj]) << (LIMB_W * (gi + gj));
        end
    end

    assign add_v[NPP] = {s1_corr, {WIDTH{1'b0}}};
`ifdef EX_MUL_PIPE_MAC_EN
    assign add_v[NPP+1] = s1_acc;
`endif

    // 3:2 compressor chain folding every aligned term into a sum/carry pair
    always_comb begin
        red_a = '0;
        red_b = '0;
        red_t = '0;
        for (int k = 0; k < NADD; k++) begin
            red_t = red_a ^ red_b ^ add_v[k];
            red_b = ((red_a & red_b) | (red_a & add_v[k]) | (red_b & add_v[k])) << 1;
            red_a = red_t;
        end
    end

    logic            s2_vld;
    logic [TAGW-1:0] s2_tag;
    logic [PW-1:0]   s2_a;
    logic [PW-1:0]   s2_b;

    // Register the redundant sum/carry form
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s2_vld <= 1'b0;
            s2_tag <= '0;
            s2_a   <= '0;
            s2_b   <= '0;
        end else if (!hold) begin
            s2_vld <= s1_vld;
            s2_tag <= s1_tag;
            s2_a   <= red_a;
            s2_b   <= red_b;
        end
    end

    // ---------------- S3: final carry-propagate add ----------------
    logic [PW-1:0]   sum_w;
    logic            s3_vld;
    logic [TAGW-1:0] s3_tag;

    ex_mul_csa_add #(
        .W (PW)
    ) u_final_add (
        .clock (clock),
        .reset (reset),
        .en    (!hold),
        .a     (s2_a),
        .b     (s2_b),
        .sum   (sum_w)
    );

    // Tag and valid ride alongside the adder's internal register level
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s3_vld <= 1'b0;
            s3_tag <= '0;
        end else if (!hold) begin
            s3_vld <= s2_vld;
            s3_tag <= s2_tag;
        end
    end

    // Result register: data and tag update only for a real op, so bubbles keep the last result
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            outValid <= 1'b0;
            valRn    <= '0;
            outTag   <= '0;
        end else if (!hold) begin
            outValid <= s3_vld;
            if (s3_vld) begin
                valRn  <= sum_w;
                outTag <= s3_tag;
            end
        end
    end

    assign busy = s0_vld | s1_vld | s2_vld | s3_vld | outValid;

endmodule

// File: tb/tb_ex_mul_pipe.sv
// Self-checking bench for ex_mul_pipe at WIDTH=32 and WIDTH=64 against a delay-line model.
// Latency: model expects results MUL_LATENCY non-held edges after sampling.
// Backpressure: hold is shared by both instances and exercised directed and at random.
module tb_ex_mul_pipe;
    import ex_mul_pkg::*;

`ifdef EX_MUL_PIPE_MAC_EN
    localparam bit MAC = 1'b1;
`else
    localparam bit MAC = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic hold  = 1'b0;
    always #5 clock = ~clock;

    // WIDTH=32 instance
    logic         vld32 = 1'b0;
    logic [1:0]   mode32 = 2'b00;
    logic [31:0]  rs32 = '0, rt32 = '0;
    logic [63:0]  acc32 = '0;
    logic [5:0]   tag32 = '0;
    logic         ov32, busy32;
    logic [63:0]  rn32;
    logic [5:0]   ot32;

    // WIDTH=64 instance
    logic         vld64 = 1'b0;
    logic [1:0]   mode64 = 2'b00;
    logic [63:0]  rs64 = '0, rt64 = '0;
    logic [127:0] acc64 = '0;
    logic [5:0]   tag64 = '0;
    logic         ov64, busy64;
    logic [127:0] rn64;
    logic [5:0]   ot64;

    ex_mul_pipe #(.WIDTH(32), .TAGW(6)) dut32 (
        .clock(clock), .reset(reset), .hold(hold), .inValid(vld32), .opMode(mode32),
        .valRs(rs32), .valRt(rt32),
`ifdef EX_MUL_PIPE_MAC_EN
        .valAcc(acc32),
`endif
        .inTag(tag32), .outValid(ov32), .valRn(rn32), .outTag(ot32), .busy(busy32)
    );

    ex_mul_pipe #(.WIDTH(64), .TAGW(6)) dut64 (
        .clock(clock), .reset(reset), .hold(hold), .inValid(vld64), .opMode(mode64),
        .valRs(rs64), .valRt(rt64),
`ifdef EX_MUL_PIPE_MAC_EN
        .valAcc(acc64),
`endif
        .inTag(tag64), .outValid(ov64), .valRn(rn64), .outTag(ot64), .busy(busy64)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference product: extend each operand to 128 bits per its signedness, multiply, truncate
    function automatic logic [127:0] ref_prod(input int w, input logic [1:0] m,
                                              input logic [63:0] rs, input logic [63:0] rt,
                                              input logic [127:0] acc);
        logic [127:0] lo_mask, a, b, p, mask;
        lo_mask = (128'd1 << w) - 128'd1;
        mask    = (w == 64) ? '1 : ((128'd1 << (2 * w)) - 128'd1);
        a = {64'd0, rs} & lo_mask;
        b = {64'd0, rt} & lo_mask;
        if (m != 2'b00 && rs[w-1]) a = a | ~lo_mask;
        if ((m == 2'b01 || m == 2'b11) && rt[w-1]) b = b | ~lo_mask;
        p = a * b;
        if (MAC && m == 2'b11) p = p + acc;
        return p & mask;
    endfunction

    // Model: per-instance delay line of MUL_LATENCY entries, advanced on non-held edges
    logic         pv [2][MUL_LATENCY];
    logic [5:0]   pt [2][MUL_LATENCY];
    logic [127:0] pd [2][MUL_LATENCY];
    logic         ev [2];
    logic [5:0]   et [2];
    logic [127:0] ed [2];
    logic         edge_held = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                for (int s = 0; s < MUL_LATENCY; s++) begin
                    pv[d][s] = 1'b0; pt[d][s] = '0; pd[d][s] = '0;
                end
                ev[d] = 1'b0; et[d] = '0; ed[d] = '0;
            end
            edge_held = 1'b0;
        end else begin
            edge_held = hold;
            if (!hold) begin
                for (int d = 0; d < 2; d++) begin
                    ev[d] = pv[d][MUL_LATENCY-1];
                    if (pv[d][MUL_LATENCY-1]) begin
                        et[d] = pt[d][MUL_LATENCY-1];
                        ed[d] = pd[d][MUL_LATENCY-1];
                    end
                    for (int s = MUL_LATENCY - 1; s > 0; s--) begin
                        pv[d][s] = pv[d][s-1]; pt[d][s] = pt[d][s-1]; pd[d][s] = pd[d][s-1];
                    end
                end
                pv[0][0] = vld32; pt[0][0] = tag32;
                pd[0][0] = ref_prod(32, mode32, {32'd0, rs32}, {32'd0, rt32}, {64'd0, acc32});
                pv[1][0] = vld64; pt[1][0] = tag64;
                pd[1][0] = ref_prod(64, mode64, rs64, rt64, acc64);
            end
        end
    end

    // Compare every cycle: outputs always defined (retained when not valid)
    always @(negedge clock) begin
        logic any0, any1;
        any0 = 1'b0; any1 = 1'b0;
        for (int s = 0; s < MUL_LATENCY; s++) begin
            any0 = any0 | pv[0][s];
            any1 = any1 | pv[1][s];
        end
        chk("cmp32_valid", ov32, ev[0]);
        chk("cmp32_tag", ot32, et[0]);
        chk("cmp32_data", {64'd0, rn32}, ed[0]);
        chk("cmp64_valid", ov64, ev[1]);
        chk("cmp64_tag", ot64, et[1]);
        chk("cmp64_data", rn64, ed[1]);
        if (any0) chk("cmp32_busy", busy32, 1);
        else if (!ev[0]) chk("cmp32_idle", busy32, 0);
        if (any1) chk("cmp64_busy", busy64, 1);
        else if (!ev[1]) chk("cmp64_idle", busy64, 0);
    end

    // Issue one op on instance d, wait for its tag, check literal value and latency
    task automatic run_op(input int d, input logic [1:0] m, input logic [63:0] rs,
                          input logic [63:0] rt, input logic [127:0] acc, input logic [5:0] tag,
                          input logic [127:0] lit, input string name);
        logic found;
        int   lat;
        logic [127:0] got;
        found = 1'b0; lat = 0; got = '0;
        @(negedge clock);
        if (d == 0) begin
            vld32 = 1'b1; mode32 = m; rs32 = rs[31:0]; rt32 = rt[31:0]; acc32 = acc[63:0]; tag32 = tag;
        end else begin
            vld64 = 1'b1; mode64 = m; rs64 = rs; rt64 = rt; acc64 = acc; tag64 = tag;
        end
        for (int i = 1; i <= 12 && !found; i++) begin
            @(negedge clock);
            if (i == 1) begin vld32 = 1'b0; vld64 = 1'b0; end
            if (d == 0 && ov32 && ot32 == tag) begin found = 1'b1; lat = i; got = {64'd0, rn32}; end
            if (d == 1 && ov64 && ot64 == tag) begin found = 1'b1; lat = i; got = rn64; end
        end
        chk({name, "_seen"}, found, 1);
        if (found) begin
            // drive on a falling edge, sample on the next rising edge, result after 4 more edges
            chk({name, "_latency"}, lat, MUL_LATENCY + 1);
            chk({name, "_value"}, got, lit);
        end
    endtask

    function automatic logic [63:0] pick(input int w);
        logic [63:0] m, v;
        m = (w == 64) ? '1 : 64'h0000_0000_FFFF_FFFF;
        case ($urandom_range(0, 5))
            0: v = '0;
            1: v = '1;
            2: v = 64'd1 << (w - 1);
            3: v = 64'd1;
            default: v = {$urandom, $urandom};
        endcase
        return v & m;
    endfunction

    initial begin
        logic [5:0]   seen_tag [$];
        int           seen_nh [$];
        int           nh;
        int           cnt;
        logic         snap_ov;
        logic [63:0]  snap_rn;
        logic [5:0]   snap_ot;

        // Reset state
        repeat (2) @(negedge clock);
        chk("reset_outValid", ov32, 0);
        chk("reset_valRn", rn32, 0);
        chk("reset_outTag", ot32, 0);
        chk("reset_busy", busy32, 0);
        chk("reset_busy64", busy64, 0);
        reset = 1'b1;

        // Directed vectors with hand-computed results
        run_op(0, 2'b00, 64'hFFFF_FFFF, 64'hFFFF_FFFF, '0, 6'd1, 128'hFFFF_FFFE_0000_0001, "uu_max");
        run_op(0, 2'b01, 64'hFFFF_FFFF, 64'hFFFF_FFFF, '0, 6'd2, 128'h1, "ss_m1");
        run_op(0, 2'b01, 64'h8000_0000, 64'h8000_0000, '0, 6'd3, 128'h4000_0000_0000_0000, "ss_min");
        run_op(0, 2'b10, 64'hFFFF_FFFF, 64'h2, '0, 6'd4, 128'hFFFF_FFFF_FFFF_FFFE, "su_m1x2");
        run_op(0, 2'b00, 64'hFFFF_FFFF, 64'h2, '0, 6'd5, 128'h1_FFFF_FFFE, "uu_x2");
`ifdef EX_MUL_PIPE_MAC_EN
        run_op(0, 2'b11, 64'd3, 64'd5, 128'h10, 6'd6, 128'h1F, "mac_3x5p16");
        run_op(0, 2'b11, 64'hFFFF_FFFF, 64'd2, 128'h5, 6'd7, 128'h3, "mac_m1x2p5");
`else
        run_op(0, 2'b11, 64'd3, 64'd5, 128'h10, 6'd6, 128'hF, "mode3_3x5");
        run_op(0, 2'b11, 64'hFFFF_FFFF, 64'hFFFF_FFFF, '0, 6'd7, 128'h1, "mode3_m1");
`endif
        run_op(1, 2'b00, '1, '1, '0, 6'd8, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, "uu64_max");
        run_op(1, 2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, '0, 6'd9,
               128'h4000_0000_0000_0000_0000_0000_0000_0000, "ss64_min");
        run_op(1, 2'b10, '1, 64'd3, '0, 6'd10, '1 - 128'd2, "su64_m1x3");

        // Stream with hold: tags 21,22,23; hold for three cycles after 21 issues
        nh = 0;
        for (int s = 0; s < 16; s++) begin
            @(negedge clock);
            if (s > 0 && !edge_held) nh++;
            if (ov32 && !edge_held) begin seen_tag.push_back(ot32); seen_nh.push_back(nh); end
            if (s == 1) begin snap_ov = ov32; snap_rn = rn32; snap_ot = ot32; end
            if (s >= 2 && s <= 4) begin
                chk("hold_frozen_valid", ov32, snap_ov);
                chk("hold_frozen_data", rn32, snap_rn);
                chk("hold_frozen_tag", ot32, snap_ot);
            end
            hold = (s >= 1 && s <= 3);
            vld32 = (s <= 5); mode32 = 2'b00; rs32 = 32'd7 + s; rt32 = 32'd9;
            tag32 = (s == 0) ? 6'd21 : (s <= 4) ? 6'd22 : 6'd23;
        end
        vld32 = 1'b0; hold = 1'b0;
        chk("hold_pulse_count", seen_tag.size(), 3);
        if (seen_tag.size() == 3) begin
            chk("hold_order_0", seen_tag[0], 21);
            chk("hold_order_1", seen_tag[1], 22);
            chk("hold_order_2", seen_tag[2], 23);
            chk("hold_edges_0", seen_nh[0], 5);
            chk("hold_edges_1", seen_nh[1], 6);
            chk("hold_edges_2", seen_nh[2], 7);
        end

        // Reset while three ops are in flight
        @(negedge clock); vld32 = 1'b1; mode32 = 2'b00; rs32 = 32'd100; rt32 = 32'd3; tag32 = 6'd30;
        @(negedge clock); tag32 = 6'd31;
        @(negedge clock); tag32 = 6'd32;
        @(negedge clock); vld32 = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("midreset_outValid", ov32, 0);
        chk("midreset_valRn", rn32, 0);
        chk("midreset_outTag", ot32, 0);
        chk("midreset_busy", busy32, 0);
        @(negedge clock); reset = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clock);
            if (ov32) cnt++;
        end
        chk("midreset_no_output", cnt, 0);

        // Random sweep on both widths, all modes, random holds and bubbles
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            hold   = ($urandom_range(0, 5) == 0);
            vld32  = ($urandom_range(0, 3) != 0);
            mode32 = 2'($urandom_range(0, 3));
            rs32   = pick(32) & 64'hFFFF_FFFF;
            rt32   = pick(32) & 64'hFFFF_FFFF;
            acc32  = {$urandom, $urandom};
            tag32  = 6'($urandom);
            vld64  = ($urandom_range(0, 3) != 0);
            mode64 = 2'($urandom_range(0, 3));
            rs64   = pick(64);
            rt64   = pick(64);
            acc64  = {pick(64), pick(64)};
            tag64  = 6'($urandom);
        end
        @(negedge clock);
        hold = 1'b0; vld32 = 1'b0; vld64 = 1'b0;
        repeat (8) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_mul_pipe.md
# ex_mul_pipe

Parametrised, fully pipelined integer multiplier for the EX stage: WIDTH×WIDTH → 2·WIDTH product with per-operation signedness (UU/SS/SU), valid/tag tracking, a global pipeline hold and an optional multiply-accumulate path. It replaces the fixed 32-bit multiplier. It sits beside the ALU and returns results to the EX3 writeback mux. It accepts one operation per clock.

## Interface
- WIDTH, 32, operand width; multiple of 16, range 16..64
- TAGW, 6, width of the opaque destination tag carried with each op
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state
- hold  in  1  global stall; 1 freezes every pipeline register
- inValid  in  1  operation present this cycle
- opMode  in  2  00 unsigned×unsigned, 01 signed×signed, 10 signed Rs × unsigned Rt, 11 see Configuration
- valRs  in  WIDTH  multiplicand
- valRt  in  WIDTH  multiplier
- valAcc  in  2·WIDTH  addend (present only with EX_MUL_PIPE_MAC_EN)
- inTag  in  TAGW  tag for this op
- outValid  out  1  valRn/outTag hold a completed result
- valRn  out  2·WIDTH  product (or product + addend)
- outTag  out  TAGW  tag of the completed op
- busy  out  1  OR of all stage valid bits

## Operation
- Limbs are 16 bits, so N = WIDTH/16 limbs per operand.
- S0: capture valRs, valRt, opMode, inTag, valAcc, and inValid into the stage-0 registers.
- S1: form the N² unsigned 16×16 partial products, one 32-bit value each.
  - Compute the sign-correction term C, mod 2^WIDTH:
    - add −Rt if Rs is treated as signed and Rs[WIDTH−1] = 1;
    - add −Rs if Rt is treated as signed and Rt[WIDTH−1] = 1.
- S2: reduce the partial products into column sums, giving two 2·WIDTH vectors A and B.
  - C is aligned at bit WIDTH, i.e. it is added into the upper half.
- S3: valRn ← (A + B) mod 2^(2·WIDTH); outTag and outValid ← the S2 values.
- Result requirements:
  - The result is exact modulo 2^(2·WIDTH) for every mode.
  - Signed×signed with both operands equal to the minimum value is exact (no hack cases).
- Valid bits travel with the data; bubbles (inValid = 0) propagate as outValid = 0.
- When outValid = 0, valRn and outTag retain their last values. Consumers ignore them.

## Timing
- Latency: an op sampled at edge k appears on valRn/outValid after edge k+4, counting only edges with hold = 0.
- Throughput: one op per non-held clock; back-to-back ops complete on consecutive cycles.
- hold = 1:
  - No register changes, including the valid bits and the output registers.
  - Inputs are ignored that cycle; the caller re-presents the op.
- hold has priority over inValid. outValid stays high across a hold if it was high.
- Reset values: outValid = 0, valRn = 0, outTag = 0, busy = 0; all stage valids = 0.
- Reset asserted mid-operation discards every in-flight op. No result is produced for ops sampled before reset.
- The first op may be sampled on the first rising edge after reset deasserts.

## Configuration
- EX_MUL_PIPE_MAC_EN defined:
  - The valAcc port exists.
  - opMode 11 = signed×signed multiply-accumulate: valRn = (Rs·Rt + valAcc) mod 2^(2·WIDTH).
  - valAcc is captured in S0 and injected as a third vector in the S2 reduction. Latency is unchanged.
- EX_MUL_PIPE_MAC_EN undefined:
  - No valAcc port and no accumulate logic.
  - opMode 11 behaves exactly as 01.

## Structure
- Shared package ex_mul_pkg:
  - opMode encodings: MUL_UU, MUL_SS, MUL_SU, MUL_MAC.
  - Limb width constant (16).
  - Pipeline latency constant (4), used by the scoreboard.
- Sub-module ex_mul_csa_add:
  - Parametrised 2·WIDTH two-input final adder used in S3.
  - Carry-select structure, so the 64-bit and 128-bit final adds meet timing.
- Partial-product generation and column reduction are generate loops in ex_mul_pipe.

## Test plan
- Unsigned mode: WIDTH = 32, opMode 00, Rs = Rt = 0xFFFFFFFF → after 4 clocks valRn = 0xFFFFFFFE00000001, outValid = 1.
- Signed mode, two cases:
  - opMode 01, Rs = Rt = 0xFFFFFFFF → valRn = 0x0000000000000001.
  - opMode 01, Rs = Rt = 0x80000000 → valRn = 0x4000000000000000.
- Mixed signedness: opMode 10, Rs = 0xFFFFFFFF, Rt = 0x00000002 → valRn = 0xFFFFFFFFFFFFFFFE; the same operands with opMode 00 → 0x00000001FFFFFFFE.
- Stream with hold: issue tags 1, 2, 3 back-to-back, then hold = 1 for 3 cycles starting the cycle after tag 1 is issued.
  - Tags emerge in order 1, 2, 3; each completes 4 non-held edges after its issue.
  - outputs are frozen during hold.
  - No duplicate or lost outValid pulses.
- Reset mid-operation: drive reset = 0 for one cycle while 3 ops are in flight → outValid = 0, valRn = 0, busy = 0 immediately (asynchronously). None of the 3 ops is ever output.
- Accumulate (with EX_MUL_PIPE_MAC_EN): opMode 11, Rs = 3, Rt = 5, valAcc = 0x10 → valRn = 0x1F.
- Random sweep at WIDTH = 64, all modes, checked against the reference-model product modulo 2^128.
